// File: rtl/fifo_pkg.sv
// Shared defaults, operation encoding and pointer-width helper for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_FIFO_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;

  // Encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned AW         = ptr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [FIFO_WIDTH-1:0] data_out
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  // Read and write to the same slot on one edge returns the old contents.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)      data_out <= '0;
    else if (rd_en) data_out <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, occupancy and flag control around fifo_mem.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned PW = ptr_width(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ok;
  logic          rd_ok;
  fifo_op_e      op;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write then.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    op = fifo_op_e'({wr_ok, rd_ok});
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      case (op)
        OP_WRITE: count <= count + CW'(1);
        OP_READ:  count <= count - CW'(1);
        default:  count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && empty)  underflow <= 1'b1;
    end
  end
`endif

  fifo_mem #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstN    (rstN),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .data_in (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .data_out(data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (FIFO_WIDTH=8, FIFO_DEPTH=16); flags checked when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rstN;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  sync_fifo #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle from a falling edge; returns on the next falling edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic rd_expect(input logic [7:0] e);
    exp_q.push_back(e);
    cyc(1'b0, 1'b1, 8'h00);
  endtask

  // Every edge that sees rd_en consumes one expectation, one time unit later.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_unexpected: got 0x%0h with no expectation queued", data_out);
        end else begin
          chk("read_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; wr_en = 1'b1; rd_en = 1'b0; data_in = 8'h77;
    repeat (5) @(negedge clk);
    chk("rst_empty_mid", {31'h0, empty}, 32'd1);
    chk("rst_full_mid", {31'h0, full}, 32'd0);
    chk("rst_dout_mid", {24'h0, data_out}, 32'h0);
    repeat (5) @(negedge clk);
    chk("rst_empty_end", {31'h0, empty}, 32'd1);
    rstN = 1'b1;

    // Fill: first write lands on the first edge after release.
    for (int unsigned i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 0)  chk("empty_after_first_wr", {31'h0, empty}, 32'd0);
      if (i == 14) chk("not_full_at_15", {31'h0, full}, 32'd0);
    end
    chk("full_after_16", {31'h0, full}, 32'd1);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("full_after_drop", {31'h0, full}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", {31'h0, overflow}, 32'd1);
    chk("underflow_clear", {31'h0, underflow}, 32'd0);
`endif

    for (int unsigned i = 0; i < 16; i++) rd_expect(8'(i));
    chk("empty_after_drain", {31'h0, empty}, 32'd1);
    rd_expect(8'h0F);
    chk("empty_after_extra_rd", {31'h0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_set", {31'h0, underflow}, 32'd1);
`endif

    // Simultaneous write and read while full.
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    chk("full_refill", {31'h0, full}, 32'd1);
    exp_q.push_back(8'h10);
    cyc(1'b1, 1'b1, 8'h55);
    chk("full_after_both", {31'h0, full}, 32'd1);
    for (int unsigned i = 1; i < 16; i++) rd_expect(8'(8'h10 + i));
    rd_expect(8'h55);
    chk("empty_after_full_both", {31'h0, empty}, 32'd1);

    // Simultaneous write and read while empty: only the write is taken.
    cyc(1'b1, 1'b0, 8'h00);
    rd_expect(8'h00);
    exp_q.push_back(8'h00);
    cyc(1'b1, 1'b1, 8'h66);
    chk("empty_both_count1", {31'h0, empty}, 32'd0);
    rd_expect(8'h66);
    chk("empty_both_drained", {31'h0, empty}, 32'd1);

    // Occupancy of 3 through repeated pointer wrap.
    for (int unsigned i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
    for (int unsigned i = 0; i < 40; i++) begin
      exp_q.push_back(8'(8'h80 + i));
      cyc(1'b1, 1'b1, 8'(8'h83 + i));
    end
    for (int unsigned i = 40; i < 43; i++) rd_expect(8'(8'h80 + i));
    chk("empty_after_wrap", {31'h0, empty}, 32'd1);

    // Asynchronous reset between edges with entries stored.
    for (int unsigned i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    rd_expect(8'hC0);
    #2;
    rstN = 1'b0;
    #1;
    chk("async_rst_empty", {31'h0, empty}, 32'd1);
    chk("async_rst_dout", {24'h0, data_out}, 32'h0);
    chk("async_rst_full", {31'h0, full}, 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("async_rst_overflow", {31'h0, overflow}, 32'd0);
    chk("async_rst_underflow", {31'h0, underflow}, 32'd0);
`endif
    @(negedge clk);
    rstN = 1'b1;
    rd_expect(8'h00);
    chk("post_rst_empty", {31'h0, empty}, 32'd1);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rstN  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  write request; data_in is stored on the rising edge when wr_en=1 and the write is accepted.
REQ-006 rd_en  input  1  read request; pops the oldest entry when rd_en=1 and the FIFO is not empty.
REQ-007 data_in  input  FIFO_WIDTH  write data.
REQ-008 data_out  output  FIFO_WIDTH  registered read data.
REQ-009 empty  output  1  high when the FIFO holds 0 entries.
REQ-010 full  output  1  high when the FIFO holds FIFO_DEPTH entries.

Function
REQ-011 The FIFO shall keep a write pointer and a read pointer of $clog2(FIFO_DEPTH) bits, plus an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
REQ-012 A write shall be accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle): mem[wr_ptr]<=data_in, wr_ptr increments modulo FIFO_DEPTH.
REQ-013 A read shall be accepted when rd_en=1 and empty=0: data_out<=mem[rd_ptr] at that edge (1-cycle latency), rd_ptr increments modulo FIFO_DEPTH.
REQ-014 When no read is accepted, data_out shall hold its previous value.
REQ-015 A write while full with no accepted read shall be dropped: pointers, count and memory are unchanged.
REQ-016 A read while empty shall be ignored: pointers, count and data_out are unchanged.
REQ-017 Simultaneous write and read when empty: only the write is accepted; count becomes 1.
REQ-018 Simultaneous accepted write and read: count unchanged; with full=1 the popped slot is the one being rewritten, and data_out shall receive the old contents.
REQ-019 Count increments on write-only, decrements on read-only, and is unchanged otherwise; empty=(count==0) and full=(count==FIFO_DEPTH), both registered or decoded from registered count with no combinational path from the inputs.
REQ-020 Pointer wrap-around from FIFO_DEPTH-1 to 0 shall preserve strict FIFO ordering.

Reset
REQ-021 While rstN=0, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, data_out=0.
REQ-022 Memory contents shall not be reset, and no entry is readable after reset.
REQ-023 Reset asserted mid-operation shall discard all stored entries immediately.
REQ-024 The first accepted write shall occur on the first rising edge after rstN deasserts.

Configuration
REQ-025 Macro FIFO_ERR_FLAGS_EN, when defined, shall add the outputs overflow (1 bit) and underflow (1 bit).
REQ-026 overflow shall be set on a dropped write (REQ-015) and underflow on an ignored read (REQ-016); both are sticky until reset and reset to 0.
REQ-027 When FIFO_ERR_FLAGS_EN is undefined, these ports and their logic shall be absent and all other behaviour shall be identical.

Structure
REQ-028 Package fifo_pkg shall hold the default width/depth constants (DEF_FIFO_WIDTH=8, DEF_FIFO_DEPTH=16) and the derived pointer-width function.
REQ-029 Storage shall be a sub-module fifo_mem: a FIFO_WIDTH x FIFO_DEPTH register array with a synchronous write port and a synchronous read port.
REQ-030 Pointer, count and flag control shall live in sync_fifo.
REQ-031 The block shall be compatible with binding a property-checker module by implicit port connection, so internal port names shall equal the interface names above.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=16)
REQ-032 Reset check: hold rstN=0 for 100 time units with wr_en=1 -> empty=1, full=0, data_out=0, and no write is accepted.
REQ-033 Write-only: write 0x00..0x0F on 16 cycles -> full=1 after the 16th edge, empty=0 after the 1st; a 17th write of 0xAA is dropped (overflow=1 when enabled).
REQ-034 Drain: after REQ-033, read 16 times -> data_out=0x00..0x0F in order, each one cycle after its rd_en edge; empty=1 after the 16th; a 17th read leaves data_out=0x0F (underflow=1 when enabled).
REQ-035 Full simultaneous: when full, assert wr_en=1 with data_in=0x55 and rd_en=1 -> data_out=oldest entry, full stays 1, and 0x55 is read last.
REQ-036 Wrap-around: run 40 interleaved write/read cycles with an occupancy of 3 -> output sequence equals input sequence with no loss.
REQ-037 Mid-operation reset: with 5 entries stored, pulse rstN low asynchronously between edges -> empty=1 and data_out=0 immediately, with no edge required.
